// File: rtl/output_blk.sv
// ---------------------------------------------------------------------------
// output_blk -- transmit end of the host UART link.
//
// Captures either a scalar result or a snapshot of the vector output buffer
// and serializes it on tx as 8N1-style frames (start, BITS data bits LSB
// first, stop). Vector responses are prefixed with a length byte so the host
// can frame them; a scalar response is a single byte.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   vec_data     N elements of BITS bits; element 0 is sent first
//   vec_len      number of valid elements (clamped to N)
//   vec_send     request a vector response (wins over scalar_send)
//   scalar_data  scalar result
//   scalar_send  request a scalar response
//   busy         high while a response is being transmitted
//   done         one-cycle pulse after the last stop bit of a response
//   tx           UART serial line, idle high
// ---------------------------------------------------------------------------
module output_blk #(
    parameter int N        = 64,
    parameter int BITS     = 8,
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 100_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] vec_data [N],
    input  logic [BITS-1:0] vec_len,
    input  logic            vec_send,
    input  logic [BITS-1:0] scalar_data,
    input  logic            scalar_send,
    output logic            busy,
    output logic            done,
    output logic            tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int IW = $clog2(N + 2);
    localparam int EW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [BW-1:0]   bit_idx;
    logic [IW-1:0]   byte_idx;   // elements already loaded for transmission
    logic [IW-1:0]   len;        // effective vector length L
    logic            is_vec;
    logic [BITS-1:0] shift;      // byte currently on the line
    logic [BITS-1:0] snapshot [N];

    logic [IW-1:0]   len_eff;
    logic            can_accept;
    logic            accept_vec;
    logic            accept_scl;
    logic            baud_wrap;

    // NOTE: every always_comb output is assigned on all paths (here by
    // unconditional expressions) so no latch is inferred.
    always_comb begin
        len_eff    = (int'(vec_len) > N) ? IW'(N) : IW'(vec_len);
        // The DONE cycle has busy low, so a request may be taken there too.
        can_accept = (state == IDLE) || (state == DONE);
        accept_vec = can_accept && vec_send;
        accept_scl = can_accept && !vec_send && scalar_send;
        baud_wrap  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    end

    // NOTE: the snapshot is pure datapath storage -- it is always written
    // before it is read, so it carries no reset and can map onto plain flops
    // or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (accept_vec) begin
            snapshot <= vec_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            len      <= '0;
            is_vec   <= 1'b0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    if (accept_vec) begin
                        // First byte of a vector response is its length.
                        state  <= START;
                        busy   <= 1'b1;
                        tx     <= 1'b0;
                        len    <= len_eff;
                        is_vec <= 1'b1;
                        shift  <= BITS'(len_eff);
                    end else if (accept_scl) begin
                        state  <= START;
                        busy   <= 1'b1;
                        tx     <= 1'b0;
                        len    <= '0;
                        is_vec <= 1'b0;
                        shift  <= scalar_data;
                    end else begin
                        state <= IDLE;
                    end
                end

                START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == BW'(BITS - 1)) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            tx      <= shift[bit_idx + BW'(1)];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        // byte_idx < len is checked before the increment, so
                        // the counter never needs to exceed N.
                        if (is_vec && (byte_idx < len)) begin
                            shift    <= snapshot[byte_idx[EW-1:0]];
                            byte_idx <= byte_idx + IW'(1);
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_blk.sv
// ---------------------------------------------------------------------------
// tb_output_blk -- scoreboard bench for output_blk (N=4, 10 clocks per bit).
//
// Stimulus pushes the expected bytes and busy lengths of each response into
// queues; a monitor decodes UART frames from tx and measures busy runs, and
// compares them against the queue heads.
// ---------------------------------------------------------------------------
module tb_output_blk;

    localparam int N        = 4;
    localparam int BITS     = 8;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int C        = CLK_FREQ / BAUD;
    localparam int FRAME    = (BITS + 2) * C;

    typedef logic [BITS-1:0] vec_t [N];

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    vec_t            vec_data;
    logic [BITS-1:0] vec_len = '0;
    logic            vec_send = 1'b0;
    logic [BITS-1:0] scalar_data = '0;
    logic            scalar_send = 1'b0;
    logic            busy;
    logic            done;
    logic            tx;

    output_blk #(
        .N        (N),
        .BITS     (BITS),
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vec_data    (vec_data),
        .vec_len     (vec_len),
        .vec_send    (vec_send),
        .scalar_data (scalar_data),
        .scalar_send (scalar_send),
        .busy        (busy),
        .done        (done),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_done = 0;
    int done_seen = 0;

    logic [BITS-1:0] byte_q [$];
    int              busy_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic            in_frame = 1'b0;
    int              pos = 0;
    int              bit_k = 0;
    logic [BITS-1:0] rx_byte = '0;
    int              run = 0;
    logic            prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            run       = 0;
            prev_busy = 1'b0;
        end else begin
            // Frame decoder: sample the middle of each bit period.
            if (!in_frame) begin
                if (tx == 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                end
            end else begin
                pos++;
            end
            if (in_frame && (pos % C) == C / 2) begin
                bit_k = pos / C;
                if (bit_k == 0) begin
                    check("start_bit", {31'd0, tx}, 32'd0);
                end else if (bit_k <= BITS) begin
                    rx_byte[bit_k-1] = tx;
                end else begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (byte_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx_byte);
                    end else begin
                        check("frame_byte", {24'd0, rx_byte}, {24'd0, byte_q.pop_front()});
                    end
                    in_frame = 1'b0;
                end
            end

            // Busy-run length and done placement.
            if (busy) begin
                run++;
            end else if (prev_busy) begin
                check("done_after_busy", {31'd0, done}, 32'd1);
                if (busy_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_busy: got run of %0d, expected none", run);
                end else begin
                    check("busy_len", run, busy_q.pop_front());
                end
                run = 0;
            end
            prev_busy = busy;

            if (done) begin
                done_seen++;
                check("done_busy_low", {31'd0, busy}, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_scalar(input logic [BITS-1:0] d);
        scalar_data = d;
        scalar_send = 1'b1;
        byte_q.push_back(d);
        busy_q.push_back(FRAME);
        exp_done++;
        @(negedge clk);
        scalar_send = 1'b0;
        scalar_data = ~d;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_tx", {31'd0, tx}, 32'd0);
    endtask

    task automatic send_scalar(input logic [BITS-1:0] d);
        @(negedge clk);
        issue_scalar(d);
    endtask

    task automatic send_vec(input logic [BITS-1:0] len, input vec_t d, input logic with_scalar);
        int l;
        @(negedge clk);
        vec_data    = d;
        vec_len     = len;
        vec_send    = 1'b1;
        scalar_send = with_scalar;
        scalar_data = 8'hFF;
        l = (int'(len) > N) ? N : int'(len);
        byte_q.push_back(BITS'(l));
        for (int i = 0; i < l; i++) byte_q.push_back(d[i]);
        busy_q.push_back((l + 1) * FRAME);
        exp_done++;
        @(negedge clk);
        vec_send    = 1'b0;
        scalar_send = 1'b0;
        // Scramble the inputs right after capture.
        for (int i = 0; i < N; i++) vec_data[i] = ~d[i];
        vec_len = 8'hFF;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_tx", {31'd0, tx}, 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || busy_q.size() != 0 || byte_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_timeout"}, {31'd0, (t < 3000)}, 32'd1);
        repeat (20) @(negedge clk);
        check({name, "_idle"}, {30'd0, busy, tx}, 32'd1);
    endtask

    initial begin
        int d_before;
        int t;
        for (int i = 0; i < N; i++) vec_data[i] = '0;

        // Reset state.
        #1 rst = 1'b1;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Scalar 0xA5.
        send_scalar(8'hA5);
        wait_idle("scalar_a5");

        // Vector, length 3; 0x44 must not be sent.
        send_vec(8'd3, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
        wait_idle("vec_len3");

        // Length 0: only the length byte.
        send_vec(8'd0, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
        wait_idle("vec_len0");

        // Length 9 clamps to 4.
        send_vec(8'd9, '{8'h5A, 8'hC3, 8'h0F, 8'hF0}, 1'b0);
        wait_idle("vec_len9");

        // Simultaneous requests: vector wins, scalar dropped.
        send_vec(8'd2, '{8'hA1, 8'hB2, 8'hC4, 8'hD8}, 1'b1);
        wait_idle("both_req");

        // Scalar pulsed mid-vector is ignored.
        send_vec(8'd1, '{8'h99, 8'h00, 8'h00, 8'h00}, 1'b0);
        repeat (150) @(negedge clk);
        scalar_data = 8'h77;
        scalar_send = 1'b1;
        @(negedge clk);
        scalar_send = 1'b0;
        wait_idle("mid_scalar");

        // Reset during DATA bit 3 of the second byte (0x81, bit 3 = 0).
        send_vec(8'd2, '{8'h81, 8'h42, 8'h00, 8'h00}, 1'b0);
        repeat (144) @(negedge clk);
        check("pre_reset_tx", {31'd0, tx}, 32'd0);
        #2;
        rst = 1'b1;
        byte_q.delete();
        busy_q.delete();
        exp_done--;
        d_before = done_seen;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no_done_after_rst", done_seen, d_before);
        check("idle_after_rst", {30'd0, busy, tx}, 32'd1);

        send_scalar(8'h3C);
        wait_idle("scalar_3c");

        // Back-to-back: new request during the DONE cycle.
        send_scalar(8'h12);
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        issue_scalar(8'h34);
        wait_idle("back_to_back");

        check("done_count", done_seen, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/output_blk.md
Name: output_blk

Overview:
- Transmit end of the host UART link; the counterpart of the receive path that drives in_bus.
- Captures either a scalar result (reduce ALU) or a vector snapshot (vector output buffer) together with its length.
- Serializes the captured data on tx as 8N1-style UART frames: BITS data bits, LSB first.
- Vector responses are length-prefixed so the Python HAL can frame them.

Parameters:
- N, 64, maximum vector elements held in the snapshot buffer
- BITS, 8, element width and number of UART data bits per frame
- CLK_FREQ, 100_000_000, clk frequency in Hz
- BAUD, 100_000, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- vec_data  input  [BITS-1:0] x N (unpacked)  vector elements; element 0 is sent first
- vec_len  input  BITS  number of valid elements in vec_data
- vec_send  input  1  request to transmit the vector response (level sampled each cycle)
- scalar_data  input  BITS  scalar result
- scalar_send  input  1  request to transmit the scalar response
- busy  output  1  high while a response is being captured or transmitted
- done  output  1  one-cycle pulse after the stop bit of the last frame of a response
- tx  output  1  UART serial line, idle high

Behaviour:
- Reset (asynchronous, any state): tx=1, busy=0, done=0, FSM=IDLE, baud counter=0, bit index=0, byte index=0. A frame in progress is abandoned; no partial stop bit is emitted.
- Accept: in IDLE with busy=0, a request is accepted on the rising edge where it is high.
  - vec_send has priority. If both requests are high, only the vector is accepted; the scalar request is dropped.
  - Requests arriving while busy=1 are ignored and are not queued.
- Capture on the accept edge:
  - Vector: all N elements are copied to an internal snapshot; the effective length L = min(vec_len, N).
  - Scalar: scalar_data is copied; the response has no length byte.
  - Inputs may change freely after the accept edge.
- busy goes high in the cycle following the accept edge. The START state begins in that same cycle, so tx goes low then.
- Byte sequence:
  - Vector response: length byte L, then snapshot[0] .. snapshot[L-1].
  - L=0: only the length byte (0x00) is sent.
  - Scalar response: one byte.
- Per-byte FSM states, each bit held for exactly CLKS_PER_BIT cycles:
  - START: tx=0.
  - DATA: tx=bit[i], i = 0..BITS-1.
  - STOP: tx=1.
  - After STOP: load the next byte into START with no idle gap, or go to DONE if no bytes remain.
- DONE: lasts one cycle. done=1 and busy=0 in that cycle (tx=1), then the FSM returns to IDLE.
  - A new request may be accepted on the edge ending the DONE cycle.
- Timing:
  - Response of K bytes: busy is high for K*(BITS+2)*CLKS_PER_BIT cycles.
  - done asserts on the cycle after the last stop-bit cycle.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and advances the bit on wrap.
  - Byte index width is clog2(N+2). Length is compared as L before send, so no wrap occurs at L=N.
- vec_len > N: clamped to N, and the length byte sent is N (not the raw vec_len).

Test Plan:
- Scalar, CLK_FREQ=1_000_000, BAUD=100_000 (10 clk/bit): scalar_data=0xA5, one-cycle scalar_send
  - tx low for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles.
  - busy high for 100 cycles, then a one-cycle done pulse.
- Vector, N=4: vec_len=3, vec_data={0x11,0x22,0x33,0x44}, vec_send pulse
  - Frames 0x03, 0x11, 0x22, 0x33 back-to-back with no idle between stop and start.
  - busy high for 400 cycles; 0x44 is never sent.
- Boundaries:
  - vec_len=0 → single frame 0x00.
  - vec_len=9 with N=4 → frames 0x04 then all 4 elements.
- Simultaneous and overlapping requests:
  - vec_send and scalar_send high on the same edge → only the vector response is sent.
  - scalar_send pulsed mid-vector → ignored, no extra frame.
  - vec_data changed one cycle after accept → transmitted bytes equal the captured values.
- Reset mid-operation: assert rst during DATA bit 3 of the second byte.
  - tx=1 and busy=0 immediately (asynchronously); done never pulses.
  - After rst release, a new scalar 0x3C transmits correctly.
- Back-to-back: re-assert scalar_send during the DONE cycle.
  - New frame starts on the next cycle; no missed or duplicated done.
